// File: rtl/fir_seq_mac_if.sv
// Streaming, coefficient-load and control signals of the sequential FIR MAC core.
// The core connects through the slave modport; the sample source/sink drives the master modport.
interface fir_seq_mac_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 16,
    parameter int OUT_W  = 16
);
    localparam int ADDR_W = $clog2(TAPS);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_sat;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     coef_ready;
    logic                     clr;
    logic                     busy;

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, clr,
        input  in_ready, out_valid, out_data, out_sat, coef_ready, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, clr,
        output in_ready, out_valid, out_data, out_sat, coef_ready, busy
    );
endinterface

// File: rtl/fir_seq_mac.sv
// Time-multiplexed FIR core: one signed multiply-accumulate per cycle over the delay line,
// followed by an arithmetic shift and saturation to OUT_W bits, with valid/ready streaming.
module fir_seq_mac #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 16,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0,
    localparam int ACC_W    = DATA_W + COEF_W + $clog2(TAPS)
) (
    input logic           clk,
    input logic           rst_n,
    fir_seq_mac_if.slave  bus
);
    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    // One spare bit above the wider of accumulator/output keeps the clamp compare exact.
    localparam int CMP_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic signed [CMP_W-1:0] SAT_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] SAT_MIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [COEF_W-1:0] h [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_fin;
    logic signed [ACC_W-1:0]  acc_sh;
    logic signed [CMP_W-1:0]  acc_ext;
    logic signed [PROD_W-1:0] prod;
    logic [IDX_W-1:0]         idx;
    logic                     last;
    logic                     accept;
    logic                     clr_now;
    logic signed [OUT_W-1:0]  sat_data;
    logic                     sat_flag;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = MAC;
            MAC:  if (last) state_nxt = OUT;
            OUT:  if (bus.out_ready) state_nxt = bus.in_valid ? MAC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = (state == IDLE) || ((state == OUT) && bus.out_ready);
        bus.coef_ready = (state == IDLE);
        bus.busy       = (state != IDLE);
    end

    always_comb begin
        last    = (idx == IDX_W'(TAPS - 1));
        accept  = bus.in_valid && bus.in_ready;
        clr_now = bus.clr && (state == IDLE);
        prod    = h[idx] * x[idx];
        acc_fin = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        acc_sh  = acc_fin >>> OUT_SHIFT;
        acc_ext = {{(CMP_W-ACC_W){acc_sh[ACC_W-1]}}, acc_sh};
        if (acc_ext > SAT_MAX) begin
            sat_data = SAT_MAX[OUT_W-1:0];
            sat_flag = 1'b1;
        end else if (acc_ext < SAT_MIN) begin
            sat_data = SAT_MIN[OUT_W-1:0];
            sat_flag = 1'b1;
        end else begin
            sat_data = acc_ext[OUT_W-1:0];
            sat_flag = 1'b0;
        end
    end

    // A clear coinciding with an accept zeroes the older taps while the new sample lands in x[0].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x[k] <= '0;
                h[k] <= '0;
            end
            acc           <= '0;
            idx           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
        end else begin
            if (bus.coef_we && bus.coef_ready) h[bus.coef_addr] <= bus.coef_data;

            if (accept) begin
                for (int k = 1; k < TAPS; k++) x[k] <= clr_now ? '0 : x[k-1];
                x[0] <= bus.in_data;
                acc  <= '0;
                idx  <= '0;
            end else if (clr_now) begin
                for (int k = 0; k < TAPS; k++) x[k] <= '0;
            end

            if (state == MAC) begin
                acc <= acc_fin;
                idx <= idx + 1'b1;
                if (last) begin
                    bus.out_data  <= sat_data;
                    bus.out_sat   <= sat_flag;
                    bus.out_valid <= 1'b1;
                end
            end

            if ((state == OUT) && bus.out_ready) bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fir_seq_mac.sv
// Self-checking bench for fir_seq_mac: an arithmetic reference model compared every cycle,
// plus directed tests with hand-computed results (impulse, saturation, backpressure, clr, reset).
module tb_fir_seq_mac;
    localparam int TAPS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   started = 1'b0;

    fir_seq_mac_if #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(16)) bus ();
    fir_seq_mac_if #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(16)) bus2 ();

    fir_seq_mac #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(16), .OUT_SHIFT(0))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    fir_seq_mac #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(16), .OUT_SHIFT(4))
        dut_sh (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_data   = bus.in_data;
    assign bus2.out_ready = bus.out_ready;
    assign bus2.coef_we   = bus.coef_we;
    assign bus2.coef_addr = bus.coef_addr;
    assign bus2.coef_data = bus.coef_data;
    assign bus2.clr       = bus.clr;

    always #5 clk = ~clk;

    // Reference model: taps and coefficients as plain integers, result computed at accept time.
    int m_x [TAPS];
    int m_h [TAPS];
    int m_mac_left = 0;
    bit m_hold = 1'b0;
    int m_res0, m_res1, p_res0, p_res1;
    bit m_sat0, m_sat1, p_sat0, p_sat1;
    int log0 [$];
    int log1 [$];
    bit logs0 [$];
    bit logs1 [$];

    function automatic void eval(input int shift, output int y, output bit s);
        longint sum = 0;
        for (int k = 0; k < TAPS; k++) sum += longint'(m_h[k]) * longint'(m_x[k]);
        sum = sum >>> shift;
        s = 1'b1;
        if (sum > 32767)       y = 32767;
        else if (sum < -32768) y = -32768;
        else begin
            y = int'(sum);
            s = 1'b0;
        end
    endfunction

    task automatic check_output(input string name, input logic signed [31:0] act,
                                input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit idle, can_accept;
        started = 1'b1;
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                m_x[k] = 0;
                m_h[k] = 0;
            end
            m_mac_left = 0;
            m_hold     = 1'b0;
            m_res0 = 0; m_res1 = 0; m_sat0 = 1'b0; m_sat1 = 1'b0;
        end else begin
            idle       = (m_mac_left == 0) && !m_hold;
            can_accept = idle || (m_hold && bus.out_ready);
            if (m_hold && bus.out_ready) m_hold = 1'b0;
            if (m_mac_left > 0) begin
                m_mac_left--;
                if (m_mac_left == 0) begin
                    m_hold = 1'b1;
                    m_res0 = p_res0; m_sat0 = p_sat0;
                    m_res1 = p_res1; m_sat1 = p_sat1;
                end
            end
            if (idle && bus.coef_we) m_h[bus.coef_addr] = int'(bus.coef_data);
            if (idle && bus.clr)
                for (int k = 0; k < TAPS; k++) m_x[k] = 0;
            if (can_accept && bus.in_valid) begin
                for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
                m_x[0] = int'(bus.in_data);
                eval(0, p_res0, p_sat0);
                eval(4, p_res1, p_sat1);
                m_mac_left = TAPS;
            end
        end
    end

    always @(negedge clk) begin
        bit idle;
        if (started) begin
            idle = (m_mac_left == 0) && !m_hold;
            check_output("in_ready", bus.in_ready, idle || (m_hold && bus.out_ready));
            check_output("coef_ready", bus.coef_ready, idle);
            check_output("busy", bus.busy, !idle);
            check_output("out_valid", bus.out_valid, m_hold);
            check_output("out_valid_sh", bus2.out_valid, m_hold);
            if (m_hold) begin
                check_output("out_data", bus.out_data, m_res0);
                check_output("out_sat", bus.out_sat, m_sat0);
                check_output("out_data_sh", bus2.out_data, m_res1);
                check_output("out_sat_sh", bus2.out_sat, m_sat1);
                if (bus.out_ready) begin
                    log0.push_back(int'(bus.out_data));
                    log1.push_back(int'(bus2.out_data));
                    logs0.push_back(bus.out_sat);
                    logs1.push_back(bus2.out_sat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_coef(input int a, input int d);
        bus.coef_we   = 1'b1;
        bus.coef_addr = a[3:0];
        bus.coef_data = d[7:0];
        tick();
        bus.coef_we   = 1'b0;
    endtask

    task automatic apply_stimulus(input int d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d[7:0];
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        check_output("accept_wait", n < 200, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (((m_mac_left != 0) || m_hold) && n < 200) begin
            tick();
            n++;
        end
        check_output("idle_wait", n < 200, 1);
    endtask

    task automatic clear_logs();
        log0.delete(); log1.delete(); logs0.delete(); logs1.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0; bus.clr = 1'b0;
        tick(); tick();
        check_output("rst_in_ready", bus.in_ready, 1);
        check_output("rst_coef_ready", bus.coef_ready, 1);
        check_output("rst_busy", bus.busy, 0);
        check_output("rst_out_valid", bus.out_valid, 0);
        check_output("rst_out_data", bus.out_data, 0);
        check_output("rst_out_sat", bus.out_sat, 0);
        rst_n = 1'b1;
        tick();

        // Impulse response with h[k] = k+1
        for (int k = 0; k < TAPS; k++) load_coef(k, k + 1);
        clear_logs();
        apply_stimulus(1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check_output("impulse_latency", n, 16);
        for (int i = 0; i < 16; i++) apply_stimulus(0);
        wait_idle();
        check_output("impulse_count", log0.size(), 17);
        for (int i = 0; i < 17 && i < log0.size(); i++) begin
            check_output("impulse_val", log0[i], (i < 16) ? i + 1 : 0);
            check_output("impulse_sat", logs0[i], 0);
        end

        // Positive and negative saturation with all h = 127
        for (int k = 0; k < TAPS; k++) load_coef(k, 127);
        clear_logs();
        for (int i = 0; i < 16; i++) apply_stimulus(127);
        wait_idle();
        check_output("satp_count", log0.size(), 16);
        if (log0.size() == 16) begin
            check_output("satp_val", log0[15], 32767);
            check_output("satp_flag", logs0[15], 1);
            check_output("satp_sh_val", log1[15], 16129);
            check_output("satp_sh_flag", logs1[15], 0);
        end
        clear_logs();
        for (int i = 0; i < 16; i++) apply_stimulus(-128);
        wait_idle();
        check_output("satn_count", log0.size(), 16);
        if (log0.size() == 16) begin
            check_output("satn_val", log0[15], -32768);
            check_output("satn_flag", logs0[15], 1);
            check_output("satn_sh_val", log1[15], -16256);
        end

        // Output shift by 4: h = 1, sixteen samples of 16
        for (int k = 0; k < TAPS; k++) load_coef(k, 1);
        clear_logs();
        for (int i = 0; i < 16; i++) apply_stimulus(16);
        wait_idle();
        check_output("shift_count", log1.size(), 16);
        if (log1.size() == 16) begin
            check_output("shift_sh_val", log1[15], 16);
            check_output("shift_sh_flag", logs1[15], 0);
            check_output("shift_val", log0[15], 256);
        end

        // Backpressure: hold the result for 10 cycles, then release with a new sample
        clear_logs();
        bus.out_ready = 1'b0;
        apply_stimulus(3);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check_output("bp_valid_wait", n < 100, 1);
        for (int i = 0; i < 10; i++) begin
            check_output("bp_in_ready", bus.in_ready, 0);
            check_output("bp_hold_data", bus.out_data, 243);
            tick();
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'sd7;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_output("bp_release_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        check_output("bp_accepted_busy", bus.busy, 1);
        check_output("bp_accepted_valid", bus.out_valid, 0);
        wait_idle();
        check_output("bp_count", log0.size(), 2);
        if (log0.size() == 2) begin
            check_output("bp_first", log0[0], 243);
            check_output("bp_second", log0[1], 234);
        end

        // Coefficient write during MAC is dropped; the same write in IDLE takes effect
        clear_logs();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        apply_stimulus(10);
        bus.coef_we = 1'b1; bus.coef_addr = 4'd0; bus.coef_data = 8'sd5;
        check_output("coef_ready_mac", bus.coef_ready, 0);
        tick();
        bus.coef_we = 1'b0;
        wait_idle();
        load_coef(0, 5);
        apply_stimulus(2);
        wait_idle();
        check_output("coef_count", log0.size(), 2);
        if (log0.size() == 2) begin
            check_output("coef_old", log0[0], 10);
            check_output("coef_new", log0[1], 20);
        end

        // clr together with a sample: only x[0] survives
        clear_logs();
        load_coef(0, 2);
        bus.clr = 1'b1;
        apply_stimulus(5);
        bus.clr = 1'b0;
        wait_idle();
        check_output("clr_count", log0.size(), 1);
        if (log0.size() == 1) check_output("clr_val", log0[0], 10);

        // Reset at idx 7 aborts the result and wipes coefficients and history
        clear_logs();
        apply_stimulus(9);
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_output("rstmid_valid", bus.out_valid, 0);
        check_output("rstmid_busy", bus.busy, 0);
        for (int i = 0; i < 20; i++) tick();
        check_output("rstmid_nolog", log0.size(), 0);
        apply_stimulus(1);
        wait_idle();
        load_coef(0, 3);
        apply_stimulus(1);
        wait_idle();
        check_output("rstmid_count", log0.size(), 2);
        if (log0.size() == 2) begin
            check_output("rstmid_zero", log0[0], 0);
            check_output("rstmid_reload", log0[1], 3);
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_seq_mac.md
# fir_seq_mac

Parametrised, time-multiplexed FIR filter core: one signed multiply-accumulate per cycle over a programmable-depth delay line, with runtime-loadable coefficients. It adds valid/ready streaming handshakes, output scaling and saturation to the earlier fixed 15-tap core. It sits between the TinyTapeout pin wrapper and the sample source/sink.

## Interface
- DATA_W, 8, sample width (signed two's complement)
- COEF_W, 8, coefficient width (signed)
- TAPS, 16, delay-line and coefficient depth (2..64)
- OUT_W, 16, output width (signed)
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
- ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width (derived; not overridden)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  sample offered
- in_ready  out  1  core accepts sample this cycle
- in_data  in  DATA_W  input sample
- out_valid  out  1  result held
- out_ready  in  1  sink accepts result
- out_data  out  OUT_W  filtered, scaled, saturated result
- out_sat  out  1  out_data was clamped (qualified by out_valid)
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  coefficient index
- coef_data  in  COEF_W  coefficient value
- coef_ready  out  1  coefficient write will be taken
- clr  in  1  zero the delay line
- busy  out  1  state is not IDLE

## Operation
- Storage: delay line x[0..TAPS-1] (x[0] newest), coefficients h[0..TAPS-1], accumulator acc (ACC_W, signed), tap index idx.
- Result: y = sum over k of h[k]*x[k], full-precision signed; then acc >>> OUT_SHIFT (floor); then clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat = 1 iff the clamp changed the value.
- FSM states:
  - IDLE: in_ready=1, coef_ready=1. On in_valid: shift x (x[k] <= x[k-1], x[0] <= in_data), acc <= 0, idx <= 0, go to MAC.
  - MAC: each cycle acc <= acc + h[idx]*x[idx], idx++. On idx==TAPS-1: register out_data/out_sat from acc + final product, out_valid <= 1, go to OUT.
  - OUT: out_valid=1; out_data/out_sat stable. On out_ready: out_valid <= 0. If in_valid is also high in the same cycle, the core accepts the new sample as in IDLE and goes to MAC. Otherwise it goes to IDLE.
- in_ready = IDLE | (OUT & out_ready). Combinational from state and out_ready only, never from in_valid.
- Coefficient write: when coef_we & coef_ready, h[coef_addr] <= coef_data. When coef_ready=0 the write is dropped silently; h is unchanged.
- clr: honoured only in IDLE; zeros all x[k]. If clr and in_valid coincide in IDLE, the clear applies first and then the sample shifts in, leaving x[0]=in_data and all other taps 0. clr is ignored outside IDLE.
- Reset (rst_n=0 at an edge): state IDLE, x and h all zero, acc=0, idx=0, out_data=0, out_sat=0, out_valid=0. Reset mid-MAC or mid-OUT aborts the operation and produces no output.

## Timing
- Latency: sample accepted at edge E; out_valid rises after edge E+TAPS.
- Throughput: one sample per TAPS+1 cycles with out_ready held high; the OUT cycle overlaps with the next accept.
- Backpressure: the core holds OUT indefinitely. out_data does not change while out_valid=1 & out_ready=0.
- Multiplier is combinational (DATA_W x COEF_W signed); one product per cycle; no pipelining inside MAC.
- Output reset values: in_ready=1, coef_ready=1, busy=0, out_valid=0, out_data=0, out_sat=0.

## Test plan
- Impulse: TAPS=16, h[k]=k+1, in 1 followed by 16 zeros, out_ready=1 -> outputs 1,2,...,16,0; out_valid rises 16 cycles after each accept; out_sat=0.
- Saturation: all h=127, feed 16 samples of 127 -> 16th output 32767 with out_sat=1. Repeat with samples of -128 -> -32768, out_sat=1. OUT_SHIFT=4 with h=1 and 16 samples of 16 -> output 16, out_sat=0.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_data stable, in_ready=0. Raise out_ready with in_valid=1 -> new sample accepted in that same cycle.
- Coefficient protection: issue coef_we during MAC -> h unchanged, result matches old coefficients. The same write issued in IDLE takes effect on the next sample.
- clr: load a nonzero history, pulse clr with in_valid=5 and h[0]=2 -> output 10.
- Reset mid-MAC: drop rst_n at idx=7 -> out_valid stays 0, all h and x read back as zero, and the next impulse gives output 0 until coefficients are reloaded.
